// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: request/grant polarity,
// FSM state encoding and master index type.
package bus_arbiter_pkg;

  localparam int NUM_MST = 4;

  // Requests and grants are active-low on the bus.
  localparam logic ENABLE  = 1'b0;
  localparam logic DISABLE = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  typedef logic [1:0] mst_idx_t;

  // Active-low grant vector with only the given master enabled.
  function automatic logic [NUM_MST-1:0] idx_to_grntn(input mst_idx_t idx);
    logic [NUM_MST-1:0] g;
    g      = '1;
    g[idx] = ENABLE;
    return g;
  endfunction

  // Active-high one-hot mask selecting the given master.
  function automatic logic [NUM_MST-1:0] idx_to_mask(input mst_idx_t idx);
    logic [NUM_MST-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin search: first active-low requester at or after
// start (wrapping 3 -> 0), skipping any master set in the exclude mask.
module rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [NUM_MST-1:0] reqn,
  input  mst_idx_t           start,
  input  logic [NUM_MST-1:0] excl,
  output mst_idx_t           idx,
  output logic               found
);

  mst_idx_t cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      // 2-bit addition wraps naturally modulo 4.
      cand = start + mst_idx_t'(i);
      if (!found && (reqn[cand] == ENABLE) && !excl[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin, non-preemptive bus arbiter with registered active-low grants
// and a one-shot hold-timeout pulse per grant.
//
// Handshake: a master requests by holding its m_reqn bit low and owns the bus
// from the edge its m_grntn bit goes low until the edge after it raises
// m_reqn; the grant is never withdrawn while the request stays low.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTER = 4,
  parameter int HOLD_LIMIT = 255
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic [NUM_MASTER-1:0] m_reqn,
  output logic [NUM_MASTER-1:0] m_grntn,
  output mst_idx_t              owner,
  output logic                  owner_vld,
  output logic                  hold_timeout,
  output arb_state_e            dbg_state
);

  localparam logic [7:0] HOLD_MAX = 8'(HOLD_LIMIT);

  arb_state_e            state_q, state_d;
  mst_idx_t              owner_q, owner_d;
  mst_idx_t              last_q;
  logic [7:0]            cnt_q, cnt_d;
  logic [NUM_MASTER-1:0] grntn_q, grntn_d;
  logic                  tout_q, tout_d;
  logic                  blank_q;
  logic                  new_grant;

  mst_idx_t              pick_start, pick_idx;
  logic [NUM_MST-1:0]    pick_excl;
  logic                  pick_found;

  rr_pick u_rr_pick (
    .reqn  (m_reqn),
    .start (pick_start),
    .excl  (pick_excl),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // State register. blank_q suppresses granting in the first cycle after reset.
  always_ff @(posedge cpu_clk) begin
    blank_q <= cpu_rst;
    if (cpu_rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      grntn_q <= '1;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (new_grant) last_q <= owner_d;
      cnt_q   <= cnt_d;
      grntn_q <= grntn_d;
      tout_q  <= tout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    new_grant  = 1'b0;
    pick_start = last_q + 2'd1;
    pick_excl  = '0;
    case (state_q)
      ST_IDLE: begin
        if (!blank_q && pick_found) begin
          state_d   = ST_GRANT;
          owner_d   = pick_idx;
          new_grant = 1'b1;
        end
      end
      ST_GRANT: begin
        pick_start = owner_q + 2'd1;
        pick_excl  = idx_to_mask(owner_q);
        if (m_reqn[owner_q] == DISABLE) begin
          if (pick_found) begin
            owner_d   = pick_idx;
            new_grant = 1'b1;
          end else begin
            state_d = ST_IDLE;
            owner_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = '0;
      end
    endcase
  end

  // Output logic: next values of the registered outputs and hold counter.
  always_comb begin
    grntn_d = '1;
    cnt_d   = cnt_q;
    tout_d  = 1'b0;
    if (state_d == ST_GRANT) grntn_d = idx_to_grntn(owner_d);
    if (new_grant || (state_d == ST_IDLE)) begin
      cnt_d = '0;
    end else if (cnt_q != HOLD_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end
    // Fires only on the transition into saturation, so once per grant.
    tout_d = (state_d == ST_GRANT) && !new_grant &&
             (cnt_q != HOLD_MAX) && (cnt_d == HOLD_MAX);
  end

  assign m_grntn      = grntn_q;
  assign owner        = owner_q;
  assign owner_vld    = (state_q == ST_GRANT);
  assign hold_timeout = tout_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: reset, single request,
// rotation, non-preemption, hold timeout, handover restart, reset mid-grant.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  logic       cpu_clk = 1'b0;
  logic       cpu_rst;
  logic [3:0] m_reqn;
  logic [3:0] m_grntn;
  mst_idx_t   owner;
  logic       owner_vld;
  logic       hold_timeout;
  arb_state_e dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses   = 0;
  bit chk_en   = 1'b0;

  bus_arbiter #(.NUM_MASTER(4), .HOLD_LIMIT(255)) dut (
    .cpu_clk      (cpu_clk),
    .cpu_rst      (cpu_rst),
    .m_reqn       (m_reqn),
    .m_grntn      (m_grntn),
    .owner        (owner),
    .owner_vld    (owner_vld),
    .hold_timeout (hold_timeout),
    .dbg_state    (dbg_state)
  );

  // Clock / reset block
  always #5 cpu_clk = ~cpu_clk;

  task automatic step();
    @(posedge cpu_clk);
    @(negedge cpu_clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Continuous grant-vector sanity on every cycle.
  always @(negedge cpu_clk) begin
    if (chk_en) begin
      n_assert++;
      assert ((m_grntn === 4'hF) || $onehot(~m_grntn))
        else begin
          n_fail++;
          $error("FAIL onehot_grntn: observed %0h expected one-hot-low or f", m_grntn);
        end
      n_assert++;
      assert (owner_vld ? (m_grntn === ~(4'b0001 << owner))
                        : ((m_grntn === 4'hF) && (owner === 2'd0)))
        else begin
          n_fail++;
          $error("FAIL owner_consistency: observed grntn=%0h owner=%0d vld=%0b", m_grntn, owner, owner_vld);
        end
    end
  end

  logic [3:0] rot_grntn [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
  logic [1:0] rot_owner [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] rel_reqn  [4] = '{4'h1, 4'h2, 4'h4, 4'h8};

  initial begin
    // Reset state
    cpu_rst = 1'b1;
    m_reqn  = 4'hF;
    step();
    chk_en = 1'b1;
    step();
    check("rst_grntn", 8'(m_grntn), 8'hF);
    check("rst_owner", 8'(owner), 8'h0);
    check("rst_vld", 8'(owner_vld), 8'h0);
    check("rst_tout", 8'(hold_timeout), 8'h0);
    check("rst_state", 8'(dbg_state), 8'(ST_IDLE));
    cpu_rst = 1'b0;
    step();
    check("blank_grntn", 8'(m_grntn), 8'hF);

    // Single request, then release to idle
    m_reqn = 4'hE;
    step();
    check("single_grntn", 8'(m_grntn), 8'hE);
    check("single_owner", 8'(owner), 8'h0);
    check("single_vld", 8'(owner_vld), 8'h1);
    check("single_state", 8'(dbg_state), 8'(ST_GRANT));
    m_reqn = 4'hF;
    step();
    check("release_grntn", 8'(m_grntn), 8'hF);
    check("release_vld", 8'(owner_vld), 8'h0);
    check("release_owner", 8'(owner), 8'h0);
    check("release_state", 8'(dbg_state), 8'(ST_IDLE));

    // Rotation with every master requesting; reset so the search starts at 0
    cpu_rst = 1'b1;
    step();
    cpu_rst = 1'b0;
    step();
    m_reqn = 4'h0;
    step();
    check("rot_first_grntn", 8'(m_grntn), 8'(rot_grntn[0]));
    for (int r = 0; r < 4; r++) begin
      repeat (2) begin
        step();
        check("rot_hold_grntn", 8'(m_grntn), 8'(rot_grntn[r]));
      end
      m_reqn = rel_reqn[r];
      step();
      check("rot_handover_grntn", 8'(m_grntn), 8'(rot_grntn[r+1]));
      check("rot_handover_owner", 8'(owner), 8'(rot_owner[r+1]));
      check("rot_handover_vld", 8'(owner_vld), 8'h1);
      m_reqn = 4'h0;
    end
    m_reqn = 4'hF;
    step();
    check("rot_idle_grntn", 8'(m_grntn), 8'hF);

    // Non-preemption: master 2 owns, master 0 waits
    m_reqn = 4'hB;
    step();
    check("np_grant2", 8'(m_grntn), 8'hB);
    m_reqn = 4'hA;
    repeat (3) begin
      step();
      check("np_hold2", 8'(m_grntn), 8'hB);
    end
    m_reqn = 4'hE;
    step();
    check("np_handover0", 8'(m_grntn), 8'hE);
    check("np_owner0", 8'(owner), 8'h0);
    m_reqn = 4'hF;
    step();
    check("np_idle", 8'(m_grntn), 8'hF);

    // Hold timeout: master 1 holds for 300 cycles
    m_reqn = 4'hD;
    step();
    check("to_grant1", 8'(m_grntn), 8'hD);
    check("to_tout_at_grant", 8'(hold_timeout), 8'h0);
    pulses = 0;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (hold_timeout) pulses++;
      check("to_pulse", 8'(hold_timeout), (i == 255) ? 8'h1 : 8'h0);
      check("to_grntn", 8'(m_grntn), 8'hD);
    end
    check("to_pulse_count", 8'(pulses), 8'h1);

    // Handover from a saturated owner restarts the counter for the new one
    m_reqn = 4'h9;
    step();
    check("bb_still1", 8'(m_grntn), 8'hD);
    m_reqn = 4'hB;
    step();
    check("bb_grant2", 8'(m_grntn), 8'hB);
    check("bb_tout_at_grant", 8'(hold_timeout), 8'h0);
    pulses = 0;
    for (int i = 1; i <= 257; i++) begin
      step();
      if (hold_timeout) pulses++;
      check("bb_pulse", 8'(hold_timeout), (i == 255) ? 8'h1 : 8'h0);
    end
    check("bb_pulse_count", 8'(pulses), 8'h1);
    m_reqn = 4'hF;
    step();
    check("bb_idle", 8'(m_grntn), 8'hF);

    // Reset mid-grant with master 3 still requesting
    m_reqn = 4'h7;
    step();
    check("mr_grant3", 8'(m_grntn), 8'h7);
    check("mr_owner3", 8'(owner), 8'h3);
    step();
    cpu_rst = 1'b1;
    step();
    check("mr_rst_grntn", 8'(m_grntn), 8'hF);
    check("mr_rst_vld", 8'(owner_vld), 8'h0);
    cpu_rst = 1'b0;
    step();
    check("mr_blank_grntn", 8'(m_grntn), 8'hF);
    step();
    check("mr_regrant", 8'(m_grntn), 8'h7);
    check("mr_reowner", 8'(owner), 8'h3);

    // Release with no requesters
    m_reqn = 4'hF;
    step();
    check("end_grntn", 8'(m_grntn), 8'hF);
    check("end_vld", 8'(owner_vld), 8'h0);
    check("end_state", 8'(dbg_state), 8'(ST_IDLE));

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
